// File: rtl/gpca_pkg.sv
// Shared widths, mode encoding and the per-stage payload of the GPCA pipeline.
package gpca_pkg;

    localparam int ROWS   = 9;
    localparam int WIDTH  = 19;
    localparam int AWIDTH = 18;
    localparam int RWIDTH = WIDTH + 1;
    // Wide enough for B << 8 (27 bits) plus a sign bit for trial subtraction.
    localparam int TWIDTH = 28;

    typedef enum logic [1:0] {
        MODE_MAC  = 2'd0,
        MODE_DIV  = 2'd1,
        MODE_SQRT = 2'd2
    } mode_e;

    typedef struct packed {
        mode_e             mode;
        logic [RWIDTH-1:0] rem;
        logic [ROWS-1:0]   fbits;
        logic [ROWS-1:0]   p;
        logic [WIDTH-1:0]  b;
        logic [AWIDTH-1:0] a;
    } stage_t;

endpackage

// File: rtl/gpca_row.sv
// One controlled add/subtract row of the array and its stage register.
// Row ROW works at bit weight 2^(ROWS-ROW) of the multiplier / quotient / root.
module gpca_row
    import gpca_pkg::*;
#(
    parameter int ROW = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam int K = ROWS - ROW;

    stage_t            stage_d;
    stage_t            stage_q;
    logic [TWIDTH-1:0] rem_wide;
    logic [TWIDTH-1:0] trial_div;
    logic [TWIDTH-1:0] trial_sqrt;
    logic [TWIDTH-1:0] diff_div;
    logic [TWIDTH-1:0] diff_sqrt;

    always_comb begin
        rem_wide   = TWIDTH'(stage_i.rem);
        trial_div  = TWIDTH'(stage_i.b) << K;
        // Root bits already resolved sit above weight 2^K, so (2F+1)*4^K in absolute terms.
        trial_sqrt = (TWIDTH'(stage_i.fbits) << (K + 1)) + (TWIDTH'(1) << (2 * K));
        diff_div   = rem_wide - trial_div;
        diff_sqrt  = rem_wide - trial_sqrt;

        stage_d = stage_i;
        case (stage_i.mode)
            MODE_MAC: begin
                if (stage_i.p[K]) begin
                    stage_d.rem = stage_i.rem + (RWIDTH'(stage_i.b) << K);
                end
            end
            MODE_DIV: begin
                if (!diff_div[TWIDTH-1]) begin
                    stage_d.rem      = RWIDTH'(diff_div);
                    stage_d.fbits[K] = 1'b1;
                end
            end
            MODE_SQRT: begin
                if (!diff_sqrt[TWIDTH-1]) begin
                    stage_d.rem      = RWIDTH'(diff_sqrt);
                    stage_d.fbits[K] = 1'b1;
                end
            end
            default: begin
                stage_d = stage_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/gpca_pipeline.sv
// Nine-row pipelined GPCA: multiply/accumulate, square root and divide on one
// array. Input decode register followed by one registered row per result bit.
module gpca_pipeline
    import gpca_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              X,
    input  logic [1:ROWS]     P,
    input  logic [1:AWIDTH]   A,
    input  logic [1:WIDTH]    B,
    input  logic [1:WIDTH]    C,
    output logic [1:ROWS]     F,
    output logic [1:WIDTH]    S
);

    stage_t in_d;
    stage_t in_q;
    stage_t stage [0:ROWS];
    logic   unused_tail;

    // The mode is fixed here and carried with the operation, so mixed streams never interfere.
    always_comb begin
        in_d       = '0;
        in_d.p     = P;
        in_d.b     = B;
        in_d.a     = A;
        in_d.fbits = '0;
        if (!X) begin
            in_d.mode = MODE_MAC;
            in_d.rem  = RWIDTH'(A) + RWIDTH'(C);
        end else if (C == B) begin
            in_d.mode = MODE_DIV;
            in_d.rem  = RWIDTH'(A);
        end else begin
            in_d.mode = MODE_SQRT;
            in_d.rem  = RWIDTH'(A);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= in_d;
        end
    end

    assign stage[0] = in_q;

    generate
        for (genvar gi = 1; gi <= ROWS; gi++) begin : g_row
            gpca_row #(
                .ROW(gi)
            ) u_row (
                .clk     (clk),
                .rst_n   (rst_n),
                .stage_i (stage[gi-1]),
                .stage_o (stage[gi])
            );
        end
    endgenerate

    assign F = stage[ROWS].fbits;
    assign S = stage[ROWS].rem[WIDTH-1:0];

    // Payload past the last row has no consumer.
    assign unused_tail = ^{stage[ROWS].rem[RWIDTH-1], stage[ROWS].mode,
                           stage[ROWS].p, stage[ROWS].b, stage[ROWS].a};

endmodule

// File: tb/tb_gpca_pipeline.sv
// Scoreboard bench for gpca_pipeline: stimulus pushes expected F/S with a due
// cycle; a negedge monitor pops and compares.
module tb_gpca_pipeline;

    logic        clk;
    logic        rst_n;
    logic        X;
    logic [1:9]  P;
    logic [1:18] A;
    logic [1:19] B;
    logic [1:19] C;
    logic [1:9]  F;
    logic [1:19] S;

    typedef struct {
        int         due;
        logic [8:0] f;
        logic [18:0] s;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    gpca_pipeline dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (X),
        .P     (P),
        .A     (A),
        .B     (B),
        .C     (C),
        .F     (F),
        .S     (S)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every output whose due cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL late_result cyc=%0d due=%0d", cyc, e.due);
            end
            n_checks++;
            if (F !== e.f) begin
                n_fail++;
                $display("FAIL F cyc=%0d got=%0d exp=%0d", cyc, F, e.f);
            end
            n_checks++;
            if (S !== e.s) begin
                n_fail++;
                $display("FAIL S cyc=%0d got=%0d exp=%0d", cyc, S, e.s);
            end else begin
                $display("cyc=%0d F=%0d S=%0d (exp F=%0d S=%0d)", cyc, F, S, e.f, e.s);
            end
        end
    end

    task automatic issue(input bit x, input int p, input int a, input int b,
                         input int c, input int ef, input int es);
        exp_t e;
        @(negedge clk);
        X = x;
        P = 9'(p);
        A = 18'(a);
        B = 19'(b);
        C = 19'(c);
        e.due = cyc + 10;
        e.f   = 9'(ef);
        e.s   = 19'(es);
        q.push_back(e);
    endtask

    task automatic zero_inputs();
        X = 1'b0;
        P = '0;
        A = '0;
        B = '0;
        C = '0;
    endtask

    // After reset, the pipeline holds zeros; the next ten outputs must be zero.
    task automatic post_reset();
        exp_t e;
        zero_inputs();
        q.delete();
        for (int j = 1; j <= 10; j++) begin
            e.due = cyc + j;
            e.f   = '0;
            e.s   = '0;
            q.push_back(e);
        end
    endtask

    task automatic check_zero_now(input string name);
        n_checks++;
        if (F !== 9'd0 || S !== 19'd0) begin
            n_fail++;
            $display("FAIL %s got F=%0d S=%0d exp F=0 S=0", name, F, S);
        end else begin
            $display("%s F=%0d S=%0d", name, F, S);
        end
    endtask

    task automatic run_set();
        issue(1'b0,   5,      0,   7,      0,   0,     35);
        issue(1'b0,   5,      3,   7,      4,   0,     42);
        issue(1'b0,   5,      0,   5,      0,   0,     25);
        issue(1'b0, 511,      0, 511,      0,   0, 261121);
        issue(1'b0,   0, 262143,   0, 524287,   0, 262142);
        issue(1'b1,   0,     25,   0,      1,   5,      0);
        issue(1'b1,   0,     26,   0,      1,   5,      1);
        issue(1'b1,   0, 262143,   0,      1, 511,   1022);
        issue(1'b1,   0,     35,   5,      5,   7,      0);
        issue(1'b1,   0,     37,   5,      5,   7,      2);
        issue(1'b1,   0,     35,   0,      0, 511,     35);
        issue(1'b1,   0, 262143,   1,      1, 511, 261632);
    endtask

    initial begin
        int wait_cnt;
        rst_n = 1'b0;
        zero_inputs();
        #3;
        check_zero_now("reset_async_start");
        @(negedge clk);
        #1 rst_n = 1'b1;
        post_reset();

        run_set();
        // Streaming mix: multiply, square, root, divide on consecutive edges.
        issue(1'b0,   5,  3,   7,  4,   0,  42);
        issue(1'b0, 511,  0, 511,  0,   0, 261121);
        issue(1'b1,   0, 26,   0,  1,   5,   1);
        issue(1'b1,   0, 37,   5,  5,   7,   2);
        for (int i = 0; i < 10; i++) issue(1'b0, 0, 0, 0, 0, 0, 0);

        // Mid-stream asynchronous reset with results in flight.
        run_set();
        @(negedge clk);
        #1;
        n_checks++;
        if (S === 19'd0) begin
            n_fail++;
            $display("FAIL pre_reset_nonzero got S=%0d exp nonzero", S);
        end
        #1 rst_n = 1'b0;
        #1 check_zero_now("reset_async_mid");
        #1 rst_n = 1'b1;
        post_reset();
        issue(1'b1, 0, 35, 5, 5, 7, 0);
        issue(1'b0, 5, 0, 5, 0, 0, 25);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d exp 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
